arm_pipelined_elastic_stage: RTL and testbench
==============================================

// Module: arm_pipelined_elastic_stage
// PURPOSE
//  Parametrised elastic pipeline register chain with valid/ready handshake, bubble collapsing and flush.
//  Successor to the fixed enable-only pipeline registers; sits between datapath stages (F/D/E/M/W boundaries).
//  A stalled stage no longer freezes the whole pipe: empty slots downstream keep accepting.
//  Flush kills in-flight entries on branch/exception redirect.
// PARAMETERS
//  BusWidth    32   payload width in bits (>=1)
//  Depth       2    number of register slots in the chain (1..8)
//  ResetValue  '0   payload value loaded into every slot on reset
// PORTS
//  i_CLK        in   1                    clock, rising edge
//  i_NRESET     in   1                    asynchronous active-low reset
//  i_VALID      in   1                    upstream payload valid
//  o_READY      out  1                    block can accept payload this cycle
//  i_DATA       in   BusWidth             upstream payload
//  o_VALID      out  1                    payload valid at last slot
//  i_READY      in   1                    downstream accepts payload
//  o_DATA       out  BusWidth             payload of last slot
//  i_FLUSH      in   1                    synchronous kill of all in-flight entries
//  o_OCCUPANCY  out  $clog2(Depth+2)      number of valid entries held (slots + skid)
// BEHAVIOUR
//  - Reset (async, i_NRESET=0): all slot valids 0, slot data = ResetValue, skid empty; o_VALID=0, o_OCCUPANCY=0,
//    o_DATA=ResetValue; o_READY=1 once reset released.
//  - Transfer: in when i_VALID&o_READY at posedge; out when o_VALID&i_READY at posedge.
//  - Slot k advance rule: rdy[k] = ~vld[k] | rdy[k+1]; rdy[Depth] = i_READY. Slot k loads slot k-1 (slot 0 loads input)
//    when rdy[k]; vld[k] <= vld[k-1] on load. Data regs load only on rdy[k]; held stable while stalled.
//  - Latency: accepted payload appears on o_DATA/o_VALID exactly Depth cycles later if never stalled. Throughput 1/cycle.
//  - Bubble collapsing: with i_READY=0, new entries accepted until all Depth slots valid, then o_READY=0.
//  - Full chain, i_VALID=1, i_READY=1: everything shifts, input accepted, occupancy unchanged.
//  - Flush: i_FLUSH=1 forces o_VALID=0 and o_READY=0 combinationally (no transfer either side);
//    all valids (incl. skid) cleared at that edge; data regs untouched. Flush dominates accept and drain.
//  - o_VALID, once high without flush, stays high with o_DATA stable until i_READY (hold rule).
//  - Occupancy: +1 on accept, -1 on drain, both or neither = unchanged, 0 after flush; never exceeds Depth(+1 w/ skid).
//  - Reset asserted mid-operation: immediate return to reset state, in-flight data discarded.
// CONFIGURATION
//  ARM_PIPE_SKID_EN defined: one-entry skid buffer at input; o_READY is a flop output = ~skid_vld & ~i_FLUSH (no
//    combinational i_READY->o_READY path). Accept with rdy[0]=0 parks payload in skid; skid drains into slot 0
//    before new input (order preserved). Skid empty: bypassed, latency still Depth. Max occupancy Depth+1.
//  Not defined: no skid; o_READY = rdy[0] & ~i_FLUSH (combinational through chain); max occupancy Depth.
// STRUCTURE
//  Package arm_pipe_pkg: localparam ARM_PIPE_MAX_DEPTH=8; typedef occupancy count type helper; struct slot_t
//    {logic vld; logic [BusWidth-1:0] data} via parametrised typedef macro.
//  Sub-module arm_pipe_slot: one slot (vld+data flops, async reset, load enable, flush clear); instanced Depth
//    times in a generate loop. Top holds ready chain, skid logic, occupancy counter.
// TESTING
//  1 Depth=3, i_READY=1, stream 0xA0..0xA7 one per cycle -> o_DATA 0xA0..0xA7 starting 3 cycles after first accept, no gaps.
//  2 Depth=3, i_READY=0, push 0x11,0x22,0x33,0x44 -> first 3 accepted, o_READY=0 on 4th, o_OCCUPANCY=3, o_DATA=0x11 held;
//    raise i_READY -> 0x11,0x22,0x33 drain in order, then 0x44 accepted.
//  3 Bubble: Depth=3, single 0x55 then idle, i_READY=0 -> 0x55 reaches last slot, o_READY stays 1 (occupancy 1).
//  4 Flush with occupancy 3 and i_VALID=1 -> o_VALID=0,o_READY=0 that cycle; next cycle occupancy 0, 0 valid outputs seen.
//  5 Async reset pulse mid-stream (between clock edges) -> o_VALID=0, o_DATA=ResetValue, o_OCCUPANCY=0 immediately.
//  6 ARM_PIPE_SKID_EN, Depth=2, i_READY=0, push 3 words -> third parks in skid, o_READY=0 next cycle, occupancy 3;
//    release -> all 3 out in order, o_READY never depends on same-cycle i_READY.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared types and helpers for the elastic pipeline stage.
// ARM_PIPE_SLOT_T / ARM_PIPE_OCC_T declare width-dependent slot and occupancy types inside a module.
`ifndef ARM_PIPE_PKG_SV
`define ARM_PIPE_PKG_SV

`define ARM_PIPE_SLOT_T(name, width) typedef struct packed { logic vld; logic [(width)-1:0] data; } name
`define ARM_PIPE_OCC_T(name, depth) typedef logic [arm_pipe_pkg::arm_pipe_occ_w(depth)-1:0] name

package arm_pipe_pkg;

  localparam int ARM_PIPE_MAX_DEPTH = 8;

  // Counter must hold 0..Depth+1 so the skid entry fits.
  function automatic int arm_pipe_occ_w(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

`endif

// File: rtl/arm_pipe_slot.sv
// One register slot of the elastic chain: valid flag plus payload, with load enable and flush clear.
// Flush only clears the valid bit; payload is left as it was.
module arm_pipe_slot #(
  parameter int                  BusWidth   = 32,
  parameter logic [BusWidth-1:0] ResetValue = '0
) (
  input  logic                i_CLK,
  input  logic                i_NRESET,
  input  logic                i_LOAD,
  input  logic                i_FLUSH,
  input  logic                i_VLD,
  input  logic [BusWidth-1:0] i_DATA,
  output logic                o_VLD,
  output logic [BusWidth-1:0] o_DATA
);

  logic                r_vld;
  logic [BusWidth-1:0] r_data;

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      r_vld  <= 1'b0;
      r_data <= ResetValue;
    end else if (i_FLUSH) begin
      r_vld  <= 1'b0;
    end else if (i_LOAD) begin
      r_vld  <= i_VLD;
      r_data <= i_DATA;
    end
  end

  assign o_VLD  = r_vld;
  assign o_DATA = r_data;

endmodule

// File: rtl/arm_pipelined_elastic_stage.sv
// Elastic valid/ready register chain with bubble collapsing, flush and occupancy count.
// Define ARM_PIPE_SKID_EN to add a one-entry input skid buffer that registers o_READY.
module arm_pipelined_elastic_stage
  import arm_pipe_pkg::*;
#(
  parameter int                  BusWidth   = 32,
  parameter int                  Depth      = 2,
  parameter logic [BusWidth-1:0] ResetValue = '0
) (
  input  logic                         i_CLK,
  input  logic                         i_NRESET,
  input  logic                         i_VALID,
  output logic                         o_READY,
  input  logic [BusWidth-1:0]          i_DATA,
  output logic                         o_VALID,
  input  logic                         i_READY,
  output logic [BusWidth-1:0]          o_DATA,
  input  logic                         i_FLUSH,
  output logic [$clog2(Depth+2)-1:0]   o_OCCUPANCY
);

  `ARM_PIPE_SLOT_T(slot_t, BusWidth);
  `ARM_PIPE_OCC_T(occ_t, Depth);

  localparam occ_t OccOne = occ_t'(1);

  logic [Depth:0]                w_rdy;
  logic [Depth-1:0]              w_vld;
  logic [Depth-1:0][BusWidth-1:0] w_data;
  slot_t                         w_in;
  logic                          w_accept;
  logic                          w_drain;
  occ_t                          r_occ;

  // An empty slot always loads from upstream, so bubbles collapse toward the output.
  assign w_rdy[Depth] = i_READY;

  for (genvar k = 0; k < Depth; k++) begin : g_slot
    logic                w_ld_vld;
    logic [BusWidth-1:0] w_ld_data;

    assign w_rdy[k] = ~w_vld[k] | w_rdy[k+1];

    if (k == 0) begin : g_head
      assign w_ld_vld  = w_in.vld;
      assign w_ld_data = w_in.data;
    end else begin : g_body
      assign w_ld_vld  = w_vld[k-1];
      assign w_ld_data = w_data[k-1];
    end

    arm_pipe_slot #(
      .BusWidth   (BusWidth),
      .ResetValue (ResetValue)
    ) u_slot (
      .i_CLK    (i_CLK),
      .i_NRESET (i_NRESET),
      .i_LOAD   (w_rdy[k]),
      .i_FLUSH  (i_FLUSH),
      .i_VLD    (w_ld_vld),
      .i_DATA   (w_ld_data),
      .o_VLD    (w_vld[k]),
      .o_DATA   (w_data[k])
    );
  end

`ifdef ARM_PIPE_SKID_EN
  slot_t r_skid;
  logic  r_ready;
  logic  w_skid_vld_d;

  // o_READY comes from a flop, so i_READY never reaches it combinationally.
  assign o_READY  = r_ready & ~i_FLUSH;
  assign w_accept = i_VALID & o_READY;
  assign w_in     = {r_skid.vld | w_accept, r_skid.vld ? r_skid.data : i_DATA};

  always_comb begin
    w_skid_vld_d = r_skid.vld;
    if (i_FLUSH) begin
      w_skid_vld_d = 1'b0;
    end else if (r_skid.vld) begin
      w_skid_vld_d = ~w_rdy[0];
    end else begin
      w_skid_vld_d = w_accept & ~w_rdy[0];
    end
  end

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      r_skid.vld  <= 1'b0;
      r_skid.data <= ResetValue;
      r_ready     <= 1'b1;
    end else begin
      r_skid.vld <= w_skid_vld_d;
      r_ready    <= ~w_skid_vld_d;
      if (w_accept && !w_rdy[0]) begin
        r_skid.data <= i_DATA;
      end
    end
  end
`else
  assign o_READY  = w_rdy[0] & ~i_FLUSH;
  assign w_accept = i_VALID & o_READY;
  assign w_in     = {w_accept, i_DATA};
`endif

  assign o_VALID = w_vld[Depth-1] & ~i_FLUSH;
  assign o_DATA  = w_data[Depth-1];
  assign w_drain = o_VALID & i_READY;

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      r_occ <= '0;
    end else if (i_FLUSH) begin
      r_occ <= '0;
    end else begin
      case ({w_accept, w_drain})
        2'b10:   r_occ <= r_occ + OccOne;
        2'b01:   r_occ <= r_occ - OccOne;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_OCCUPANCY = r_occ;

endmodule

// File: tb/tb_arm_pipelined_elastic_stage.sv
// Randomised and directed bench for arm_pipelined_elastic_stage with a position-based reference model
// and a data scoreboard. Define ARM_PIPE_SKID_EN to exercise the skid-buffer build.
module tb_arm_pipelined_elastic_stage;

  localparam int BW = 8;
`ifdef ARM_PIPE_SKID_EN
  localparam int DEPTH = 2;
  localparam bit SKID  = 1'b1;
`else
  localparam int DEPTH = 3;
  localparam bit SKID  = 1'b0;
`endif
  localparam int OW = $clog2(DEPTH + 2);
  localparam logic [BW-1:0] RV = 8'h5A;

  logic          i_CLK = 1'b0;
  logic          i_NRESET = 1'b0;
  logic          i_VALID = 1'b0;
  logic          o_READY;
  logic [BW-1:0] i_DATA = '0;
  logic          o_VALID;
  logic          i_READY = 1'b0;
  logic [BW-1:0] o_DATA;
  logic          i_FLUSH = 1'b0;
  logic [OW-1:0] o_OCCUPANCY;

  arm_pipelined_elastic_stage #(
    .BusWidth   (BW),
    .Depth      (DEPTH),
    .ResetValue (RV)
  ) dut (
    .i_CLK       (i_CLK),
    .i_NRESET    (i_NRESET),
    .i_VALID     (i_VALID),
    .o_READY     (o_READY),
    .i_DATA      (i_DATA),
    .o_VALID     (o_VALID),
    .i_READY     (i_READY),
    .o_DATA      (o_DATA),
    .i_FLUSH     (i_FLUSH),
    .o_OCCUPANCY (o_OCCUPANCY)
  );

  always #5 i_CLK = ~i_CLK;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: ordered list of entry positions (0 = first slot, DEPTH-1 = output),
  // plus a skid flag. Payloads live only in the scoreboard queue.
  int            mpos[$];
  int            newp[$];
  bit            mskid = 1'b0;
  bit            model_on = 1'b0;
  logic [BW-1:0] sb_q[$];
  int            m_cap;
  bit            m_free;
  bit            m_rdy;
  bit            m_vld;

  function automatic void model_clear();
    mpos.delete();
    mskid = 1'b0;
    sb_q.delete();
  endfunction

  always @(negedge i_CLK) begin
    if (i_NRESET && model_on) begin
      newp.delete();
      for (int i = 0; i < mpos.size(); i++) begin
        if (i == 0) m_cap = i_READY ? DEPTH : DEPTH - 1;
        else        m_cap = newp[i-1] - 1;
        newp.push_back((mpos[i] + 1 < m_cap) ? mpos[i] + 1 : m_cap);
      end
      m_free = (newp.size() == 0) || (newp[newp.size()-1] >= 1);
      m_vld  = !i_FLUSH && (mpos.size() > 0) && (mpos[0] == DEPTH - 1);
      m_rdy  = !i_FLUSH && (SKID ? !mskid : m_free);

      chk("occupancy", 32'(o_OCCUPANCY), 32'(mpos.size() + int'(mskid)));
      chk("o_valid", 32'(o_VALID), 32'(m_vld));
      chk("o_ready", 32'(o_READY), 32'(m_rdy));

      if (i_FLUSH) begin
        model_clear();
      end else begin
        while (newp.size() > 0 && newp[0] == DEPTH) void'(newp.pop_front());
        mpos = newp;
        if (mskid && m_free) begin
          mpos.push_back(0);
          mskid = 1'b0;
        end else if (i_VALID && m_rdy) begin
          if (m_free) mpos.push_back(0);
          else        mskid = 1'b1;
        end
        if (i_VALID && m_rdy) sb_q.push_back(i_DATA);
      end
    end
  end

  // Monitor: every drained beat must be the oldest outstanding accepted payload.
  always @(negedge i_CLK) begin
    #2;
    if (i_NRESET && model_on && o_VALID && i_READY) begin
      if (sb_q.size() == 0) chk("unexpected_output", 32'(o_DATA), 32'hFFFF_FFFF);
      else                  chk("out_data", 32'(o_DATA), 32'(sb_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic do_reset();
    model_on = 1'b0;
    i_NRESET = 1'b0;
    i_VALID  = 1'b0;
    i_FLUSH  = 1'b0;
    repeat (2) tick();
    chk("rst_o_valid", 32'(o_VALID), 32'd0);
    chk("rst_o_data", 32'(o_DATA), 32'(RV));
    chk("rst_occupancy", 32'(o_OCCUPANCY), 32'd0);
    model_clear();
    i_NRESET = 1'b1;
    #1;
    chk("rst_o_ready", 32'(o_READY), 32'd1);
    model_on = 1'b1;
  endtask

  // Hold one beat valid until the handshake completes (bounded).
  task automatic send(input logic [BW-1:0] d);
    bit acc = 1'b0;
    i_VALID = 1'b1;
    i_DATA  = d;
    for (int n = 0; n < 64; n++) begin
      @(negedge i_CLK);
      acc = o_READY;
      tick();
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    i_VALID = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    do_reset();

    // Full-rate stream with no backpressure.
    i_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_VALID = 1'b1;
      i_DATA  = 8'hA0 + 8'(i);
      tick();
    end
    i_VALID = 1'b0;
    repeat (DEPTH + 3) tick();

    // Backpressure fills the chain, then drains in order.
    i_READY = 1'b0;
    send(8'h11);
    send(8'h22);
    send(8'h33);
    i_VALID = 1'b1;
    i_DATA  = 8'h44;
    repeat (3) begin
      @(negedge i_CLK);
      chk("full_o_ready", 32'(o_READY), 32'd0);
      chk("full_occupancy", 32'(o_OCCUPANCY), 32'd3);
      chk("full_hold_data", 32'(o_DATA), 32'h11);
      chk("full_o_valid", 32'(o_VALID), 32'd1);
      tick();
    end
    i_READY = 1'b1;
    send(8'h44);
    repeat (DEPTH + 4) tick();

    // Single beat collapses to the output slot while stalled.
    do_reset();
    i_READY = 1'b0;
    send(8'h55);
    repeat (DEPTH + 2) tick();
    @(negedge i_CLK);
    chk("bubble_o_ready", 32'(o_READY), 32'd1);
    chk("bubble_occupancy", 32'(o_OCCUPANCY), 32'd1);
    chk("bubble_o_data", 32'(o_DATA), 32'h55);
    tick();

    // Flush with a full chain and a pending input.
    send(8'h66);
    send(8'h77);
    i_VALID = 1'b1;
    i_DATA  = 8'h88;
    i_FLUSH = 1'b1;
    @(negedge i_CLK);
    chk("flush_o_valid", 32'(o_VALID), 32'd0);
    chk("flush_o_ready", 32'(o_READY), 32'd0);
    tick();
    i_FLUSH = 1'b0;
    i_VALID = 1'b0;
    i_READY = 1'b1;
    @(negedge i_CLK);
    chk("post_flush_occ", 32'(o_OCCUPANCY), 32'd0);
    tick();
    repeat (DEPTH + 2) tick();

    // Asynchronous reset pulse between edges.
    for (int i = 0; i < DEPTH + 2; i++) begin
      i_VALID = 1'b1;
      i_DATA  = 8'hC0 + 8'(i);
      tick();
    end
    #2;
    i_NRESET = 1'b0;
    #1;
    chk("async_rst_o_valid", 32'(o_VALID), 32'd0);
    chk("async_rst_o_data", 32'(o_DATA), 32'(RV));
    chk("async_rst_occ", 32'(o_OCCUPANCY), 32'd0);
    i_VALID = 1'b0;
    model_clear();
    i_NRESET = 1'b1;
    repeat (3) tick();

`ifdef ARM_PIPE_SKID_EN
    // Third beat parks in the skid; o_READY ignores same-cycle i_READY.
    do_reset();
    i_READY = 1'b0;
    send(8'h01);
    send(8'h02);
    send(8'h03);
    chk("skid_o_ready", 32'(o_READY), 32'd0);
    chk("skid_occupancy", 32'(o_OCCUPANCY), 32'd3);
    i_READY = 1'b1;
    #1;
    chk("skid_rdy_indep_hi", 32'(o_READY), 32'd0);
    i_READY = 1'b0;
    #1;
    chk("skid_rdy_indep_lo", 32'(o_READY), 32'd0);
    i_READY = 1'b1;
    repeat (DEPTH + 4) tick();
`endif

    // Randomised traffic with occasional flushes.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      i_VALID = ($urandom_range(0, 9) < 7);
      i_READY = ($urandom_range(0, 9) < 6);
      i_FLUSH = ($urandom_range(0, 39) == 0);
      i_DATA  = BW'($urandom);
      tick();
    end
    i_VALID = 1'b0;
    i_FLUSH = 1'b0;
    i_READY = 1'b1;
    repeat (DEPTH + 4) tick();
    chk("final_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
